// File: rtl/pe_load_scheduler_if.sv
// Bundle of the SRAM ports and PE buffer strobes that the load scheduler drives.
// master = scheduler side, slave = SRAM/PE side.
interface pe_load_scheduler_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] sram_raddr;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic                  sram_ren;
    logic [ADDR_WIDTH-1:0] sram_waddr;
    logic                  sram_wen;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic                  filter_wen;
    logic [DATA_WIDTH-1:0] filter_din;
    logic                  filter_full;
    logic                  IF_wen;
    logic [DATA_WIDTH-1:0] IF_din;
    logic                  IF_full;
    logic                  pe_start;
    logic                  pe_done;
    logic                  outbuf_ren;
    logic [OUT_WIDTH-1:0]  outbuf_dout;
    logic                  outbuf_empty;

    modport master (
        output sram_raddr, sram_ren, sram_waddr, sram_wen, sram_wdata,
        output filter_wen, filter_din, IF_wen, IF_din, pe_start, outbuf_ren,
        input  sram_rdata, filter_full, IF_full, pe_done, outbuf_dout, outbuf_empty
    );

    modport slave (
        input  sram_raddr, sram_ren, sram_waddr, sram_wen, sram_wdata,
        input  filter_wen, filter_din, IF_wen, IF_din, pe_start, outbuf_ren,
        output sram_rdata, filter_full, IF_full, pe_done, outbuf_dout, outbuf_empty
    );
endinterface

// File: rtl/pe_load_scheduler.sv
// Job sequencer: SRAM -> PE filter/IF FIFOs, PE start, then PE output buffer -> SRAM.
// Owns every SRAM enable/address and every PE buffer strobe.
module pe_load_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] filt_base,
    input  logic [CNT_WIDTH-1:0]  filt_count,
    input  logic [ADDR_WIDTH-1:0] if_base,
    input  logic [CNT_WIDTH-1:0]  if_count,
    input  logic [ADDR_WIDTH-1:0] out_base,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  out_count,
    pe_load_scheduler_if.master   bus
);

    typedef enum logic [2:0] {IDLE, LD_FILT, LD_IF, RUN, DRAIN, DONE} state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] filt_base;
        logic [CNT_WIDTH-1:0]  filt_count;
        logic [ADDR_WIDTH-1:0] if_base;
        logic [CNT_WIDTH-1:0]  if_count;
        logic [ADDR_WIDTH-1:0] out_base;
    } cfg_t;

    state_e                state_q, state_d;
    cfg_t                  cfg_q, cfg_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]  push_cnt_q, push_cnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  pe_done_q, pe_done_d;
    logic                  started_q, started_d;
    logic                  pop_pend_q, pop_pend_d;
    logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;

    logic                  loading, avail, push, rd, last_push, pop, wen, cur_full;
    logic [ADDR_WIDTH-1:0] cur_base;
    logic [CNT_WIDTH-1:0]  cur_cnt;
    logic [DATA_WIDTH-1:0] word;

    // Word available to push is the held word, else the SRAM word arriving this cycle.
    // A read is only issued if nothing will be left over afterwards, so the single
    // holding register can always absorb the in-flight word on a stall.
    always_comb begin
        loading   = (state_q == LD_FILT) || (state_q == LD_IF);
        cur_base  = (state_q == LD_IF) ? cfg_q.if_base  : cfg_q.filt_base;
        cur_cnt   = (state_q == LD_IF) ? cfg_q.if_count : cfg_q.filt_count;
        cur_full  = (state_q == LD_IF) ? bus.IF_full    : bus.filter_full;
        avail     = hold_vld_q | rd_pend_q;
        word      = hold_vld_q ? hold_q : bus.sram_rdata;
        push      = loading && avail && !cur_full;
        rd        = loading && (rd_cnt_q != cur_cnt) && (!avail || push);
        last_push = push && (push_cnt_q == cur_cnt - CNT_WIDTH'(1));
        pop       = (state_q == DRAIN) && pe_done_q && !bus.outbuf_empty;
        wen       = (state_q == DRAIN) && pop_pend_q;
    end

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        rd_cnt_d   = rd ? rd_cnt_q + CNT_WIDTH'(1) : rd_cnt_q;
        push_cnt_d = push ? push_cnt_q + CNT_WIDTH'(1) : push_cnt_q;
        rd_pend_d  = rd;
        hold_vld_d = avail && !push;
        hold_d     = hold_vld_q ? hold_q : bus.sram_rdata;
        pe_done_d  = (state_q == IDLE) ? 1'b0 : (pe_done_q | bus.pe_done);
        started_d  = (state_q == RUN);
        pop_pend_d = pop;
        out_cnt_d  = (wen && (out_cnt_q != '1)) ? out_cnt_q + CNT_WIDTH'(1) : out_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d.filt_base  = filt_base;
                    cfg_d.filt_count = filt_count;
                    cfg_d.if_base    = if_base;
                    cfg_d.if_count   = if_count;
                    cfg_d.out_base   = out_base;
                    out_cnt_d        = '0;
                    rd_cnt_d         = '0;
                    push_cnt_d       = '0;
                    if (filt_count != '0)    state_d = LD_FILT;
                    else if (if_count != '0) state_d = LD_IF;
                    else                     state_d = RUN;
                end
            end
            LD_FILT: begin
                if (last_push) begin
                    rd_cnt_d   = '0;
                    push_cnt_d = '0;
                    state_d    = (cfg_q.if_count != '0) ? LD_IF : RUN;
                end
            end
            LD_IF: begin
                if (last_push) begin
                    rd_cnt_d   = '0;
                    push_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            RUN:     if (pe_done_q) state_d = DRAIN;
            DRAIN:   if (bus.outbuf_empty && !pop_pend_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            rd_cnt_q   <= '0;
            push_cnt_q <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            pe_done_q  <= 1'b0;
            started_q  <= 1'b0;
            pop_pend_q <= 1'b0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            rd_cnt_q   <= rd_cnt_d;
            push_cnt_q <= push_cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            rd_pend_q  <= rd_pend_d;
            pe_done_q  <= pe_done_d;
            started_q  <= started_d;
            pop_pend_q <= pop_pend_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    // Data/address outputs are gated by their strobes so idle outputs read as zero.
    assign bus.sram_ren   = rd;
    assign bus.sram_raddr = rd ? cur_base + ADDR_WIDTH'(rd_cnt_q) : '0;
    assign bus.filter_wen = push && (state_q == LD_FILT);
    assign bus.filter_din = (push && (state_q == LD_FILT)) ? word : '0;
    assign bus.IF_wen     = push && (state_q == LD_IF);
    assign bus.IF_din     = (push && (state_q == LD_IF)) ? word : '0;
    assign bus.pe_start   = (state_q == RUN) && !started_q;
    assign bus.outbuf_ren = pop;
    assign bus.sram_wen   = wen;
    assign bus.sram_waddr = wen ? cfg_q.out_base + ADDR_WIDTH'(out_cnt_q) : '0;
    assign bus.sram_wdata = wen ? DATA_WIDTH'(bus.outbuf_dout) : '0;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_count = out_cnt_q;

endmodule

// File: tb/tb_pe_load_scheduler.sv
// Bench for pe_load_scheduler: SRAM/PE behavioural models, a per-cycle checker
// against expected word streams, and directed jobs with literal pins.
module tb_pe_load_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] filt_base = '0, filt_count = '0, if_base = '0, if_count = '0, out_base = '0;
    logic       busy, done;
    logic [7:0] out_count;

    pe_load_scheduler_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .OUT_WIDTH(16)) bus ();

    pe_load_scheduler #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .filt_base(filt_base), .filt_count(filt_count), .if_base(if_base),
        .if_count(if_count), .out_base(out_base),
        .busy(busy), .done(done), .out_count(out_count),
        .bus(bus.master)
    );

    initial forever #5 clk = ~clk;

    int vec = 0;
    int miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // SRAM + PE environment
    logic [15:0] mem [256];
    logic [15:0] res [$];
    logic [15:0] ob [$];
    int          pe_lat = 2;
    bit          early = 1'b0;

    // negedge samples of DUT outputs
    logic       n_ren = 0, n_wen = 0, n_fwen = 0, n_iwen = 0, n_pst = 0, n_oren = 0, n_busy = 0;
    logic [7:0] n_raddr = 0, n_waddr = 0;
    logic [15:0] n_wdata = 0, n_fdin = 0, n_idin = 0;

    initial begin
        int  pe_cnt;
        bit  pb, fire;
        pe_cnt = 0;
        pb = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
        bus.sram_rdata   = '0;
        bus.outbuf_dout  = '0;
        bus.outbuf_empty = 1'b1;
        bus.pe_done      = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                pe_cnt = 0;
                pb = 0;
                ob.delete();
                bus.pe_done      <= 1'b0;
                bus.sram_rdata   <= '0;
                bus.outbuf_dout  <= '0;
                bus.outbuf_empty <= 1'b1;
            end else begin
                if (n_ren) bus.sram_rdata <= mem[n_raddr];
                if (n_wen) mem[n_waddr] = n_wdata;
                if (n_oren && ob.size() > 0) bus.outbuf_dout <= ob.pop_front();
                fire = 0;
                if (early ? (n_busy && !pb) : n_pst) pe_cnt = pe_lat;
                else if (pe_cnt > 0) begin
                    pe_cnt--;
                    fire = (pe_cnt == 0);
                end
                pb = n_busy;
                if (fire) ob = res;
                bus.pe_done      <= fire;
                bus.outbuf_empty <= (ob.size() == 0);
            end
        end
    end

    // Reference job model: expected streams derived from the latched config and memory.
    logic [15:0] exp_f [$], exp_i [$], exp_o [$], f_got [$], i_got [$];
    int          fidx = 0, iidx = 0, widx = 0, pstarts = 0, dones = 0;
    bit          pe_seen = 0, exp_busy = 0, first_cyc = 0;
    logic [7:0]  jb_fb = 0, jb_fc = 0, jb_ib = 0, jb_ic = 0, jb_ob = 0;

    initial begin
        forever begin
            @(negedge clk);
            n_ren = bus.sram_ren;     n_raddr = bus.sram_raddr;
            n_wen = bus.sram_wen;     n_waddr = bus.sram_waddr;  n_wdata = bus.sram_wdata;
            n_fwen = bus.filter_wen;  n_fdin = bus.filter_din;
            n_iwen = bus.IF_wen;      n_idin = bus.IF_din;
            n_pst = bus.pe_start;     n_oren = bus.outbuf_ren;   n_busy = busy;
            if (!rst) begin
                chk("rst_outputs", 32'({busy, done, n_ren, n_wen, n_fwen, n_iwen, n_pst, n_oren,
                    |out_count, |n_raddr, |n_waddr, |n_wdata, |n_fdin, |n_idin}), 32'd0);
                exp_busy = 0;
                first_cyc = 0;
                pe_seen = 0;
            end else begin
                chk("busy", 32'(busy), 32'(exp_busy));
                if (first_cyc) begin
                    chk("first_ren", 32'(n_ren), 32'(jb_fc != 0 || jb_ic != 0));
                    if (n_ren) chk("first_raddr", 32'(n_raddr), 32'(jb_fc != 0 ? jb_fb : jb_ib));
                    first_cyc = 0;
                end
                if (n_fwen) begin
                    chk("filter_wen_while_full", 32'(bus.filter_full), 32'd0);
                    if (fidx < exp_f.size()) chk("filter_din", 32'(n_fdin), 32'(exp_f[fidx]));
                    else chk("filter_extra", 32'(fidx + 1), 32'(exp_f.size()));
                    f_got.push_back(n_fdin);
                    fidx++;
                end
                if (n_iwen) begin
                    chk("IF_wen_while_full", 32'(bus.IF_full), 32'd0);
                    if (iidx < exp_i.size()) chk("IF_din", 32'(n_idin), 32'(exp_i[iidx]));
                    else chk("IF_extra", 32'(iidx + 1), 32'(exp_i.size()));
                    i_got.push_back(n_idin);
                    iidx++;
                end
                if (n_ren)  chk("ren_after_pe_start", 32'(pe_seen), 32'd0);
                if (n_oren) chk("oren_before_pe_start", 32'(pe_seen), 32'd1);
                if (n_wen) begin
                    chk("wen_before_pe_start", 32'(pe_seen), 32'd1);
                    chk("sram_waddr", 32'(n_waddr), 32'(8'(jb_ob + 8'(widx))));
                    if (widx < exp_o.size()) chk("sram_wdata", 32'(n_wdata), 32'(exp_o[widx]));
                    else chk("write_extra", 32'(widx + 1), 32'(exp_o.size()));
                    widx++;
                end
                if (n_pst) begin
                    chk("pe_start_filt_done", 32'(fidx), 32'(exp_f.size()));
                    chk("pe_start_if_done", 32'(iidx), 32'(exp_i.size()));
                    pe_seen = 1;
                    pstarts++;
                end
                if (done) begin
                    dones++;
                    chk("out_count_at_done", 32'(out_count), 32'(exp_o.size()));
                end
                if (done) exp_busy = 0;
                else if (start && !exp_busy) begin
                    jb_fb = filt_base; jb_fc = filt_count; jb_ib = if_base;
                    jb_ic = if_count;  jb_ob = out_base;
                    exp_f.delete(); exp_i.delete(); f_got.delete(); i_got.delete();
                    for (int k = 0; k < int'(filt_count); k++) exp_f.push_back(mem[8'(filt_base + 8'(k))]);
                    for (int k = 0; k < int'(if_count); k++) exp_i.push_back(mem[8'(if_base + 8'(k))]);
                    exp_o = res;
                    fidx = 0; iidx = 0; widx = 0; pstarts = 0; dones = 0;
                    pe_seen = 0;
                    exp_busy = 1;
                    first_cyc = 1;
                end
            end
        end
    end

    task automatic kick(input logic [7:0] fb, input logic [7:0] fc, input logic [7:0] ib,
                        input logic [7:0] ic, input logic [7:0] ob_a, input int lat, input bit erl);
        @(posedge clk); #1;
        filt_base = fb; filt_count = fc; if_base = ib; if_count = ic; out_base = ob_a;
        pe_lat = lat; early = erl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_job(input string nm);
        int n;
        n = 0;
        while (dones == 0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk({nm, "_done_timeout"}, 32'(dones != 0), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk({nm, "_done_count"}, 32'(dones), 32'd1);
        chk({nm, "_pe_start_count"}, 32'(pstarts), 32'd1);
        chk({nm, "_filter_words"}, 32'(fidx), 32'(exp_f.size()));
        chk({nm, "_IF_words"}, 32'(iidx), 32'(exp_i.size()));
        chk({nm, "_writes"}, 32'(widx), 32'(exp_o.size()));
        chk({nm, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_fwen(input int target, input bit want_if);
        int n;
        n = 0;
        while ((want_if ? iidx : fidx) < target && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wait_push_timeout", 32'((want_if ? iidx : fidx) >= target), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.filter_full = 1'b0;
        bus.IF_full     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        chk("reset_sram_ren", 32'(bus.sram_ren), 32'd0);
        rst = 1'b1;

        // basic load / drain job
        res = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5};
        kick(8'h10, 8'd3, 8'h20, 8'd4, 8'h80, 3, 1'b0);
        finish_job("basic");
        for (int k = 0; k < 3; k++) chk("basic_filt_word", 32'(f_got.size() > k ? f_got[k] : 16'h0), 32'(16'hC010 + 16'(k)));
        for (int k = 0; k < 4; k++) chk("basic_if_word", 32'(i_got.size() > k ? i_got[k] : 16'h0), 32'(16'hC020 + 16'(k)));
        for (int k = 0; k < 5; k++) chk("basic_sram_result", 32'(mem[8'h80 + k]), 32'(16'h00A1 + 16'(k)));
        chk("basic_out_count", 32'(out_count), 32'd5);

        // back-pressure on both FIFOs
        res = '{16'h00B1, 16'h00B2};
        kick(8'h10, 8'd3, 8'h20, 8'd4, 8'h90, 2, 1'b0);
        wait_fwen(1, 1'b0);
        @(posedge clk); #1;
        bus.filter_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_filter_held", 32'(fidx), 32'd1);
        bus.filter_full = 1'b0;
        wait_fwen(1, 1'b1);
        @(posedge clk); #1;
        bus.IF_full = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_IF_held", 32'(iidx), 32'd1);
        bus.IF_full = 1'b0;
        finish_job("stall");
        for (int k = 0; k < 3; k++) chk("stall_filt_word", 32'(f_got.size() > k ? f_got[k] : 16'h0), 32'(16'hC010 + 16'(k)));
        chk("stall_sram_result", 32'(mem[8'h91]), 32'h00B2);

        // no filter words, IF address wraps, PE done arrives during the load
        res = '{16'h1234};
        kick(8'h10, 8'd0, 8'hFE, 8'd4, 8'hB8, 2, 1'b1);
        finish_job("skip_wrap");
        chk("skip_no_filter", 32'(f_got.size()), 32'd0);
        chk("wrap_if_word0", 32'(i_got.size() > 0 ? i_got[0] : 16'h0), 32'h0000C0FE);
        chk("wrap_if_word2", 32'(i_got.size() > 2 ? i_got[2] : 16'h0), 32'h0000C000);
        chk("early_result", 32'(mem[8'hB8]), 32'h1234);

        // reset during IFmap load, then a clean job
        res = '{16'h00C1, 16'h00C2};
        kick(8'h10, 8'd3, 8'h20, 8'd4, 8'hA0, 2, 1'b0);
        wait_fwen(1, 1'b1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("abort_outputs", 32'({busy, done, bus.sram_ren, bus.IF_wen, bus.filter_wen,
            bus.pe_start, bus.sram_wen, bus.outbuf_ren}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort_no_done", 32'(dones), 32'd0);
        kick(8'h10, 8'd3, 8'h20, 8'd4, 8'hA0, 2, 1'b0);
        finish_job("after_reset");
        for (int k = 0; k < 4; k++) chk("after_reset_if_word", 32'(i_got.size() > k ? i_got[k] : 16'h0), 32'(16'hC020 + 16'(k)));
        chk("after_reset_result", 32'(mem[8'hA1]), 32'h00C2);

        // start pulse during drain is ignored
        res = '{16'h00D1, 16'h00D2, 16'h00D3, 16'h00D4};
        kick(8'h10, 8'd1, 8'h20, 8'd1, 8'hB0, 1, 1'b0);
        n = 0;
        while (!bus.outbuf_ren && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_reached", 32'(bus.outbuf_ren), 32'd1);
        @(posedge clk); #1;
        filt_base = 8'h40; filt_count = 8'd2; out_base = 8'hE0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_job("start_in_drain");
        repeat (5) @(negedge clk);
        #1;
        chk("start_in_drain_idle", 32'(busy), 32'd0);
        chk("start_in_drain_result", 32'(mem[8'hB3]), 32'h00D4);
        chk("start_in_drain_out_count", 32'(out_count), 32'd4);

        // empty job: no loads, no results
        res.delete();
        kick(8'h00, 8'd0, 8'h00, 8'd0, 8'hC0, 2, 1'b0);
        finish_job("empty");
        chk("empty_out_count", 32'(out_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
